// File: rtl/mc_alu_pkg.sv
// Shared opcode/state encodings and flag bit positions for the multi-cycle ALU.
package mc_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MPY = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_NOT = 4'd5,
    OP_SHR = 4'd6,
    OP_SHL = 4'd7,
    OP_DIV = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned FLG_W  = 6;
  localparam int unsigned FLG_ZF = 5;
  localparam int unsigned FLG_CF = 4;
  localparam int unsigned FLG_OF = 3;
  localparam int unsigned FLG_NF = 2;
  localparam int unsigned FLG_MF = 1;
  localparam int unsigned FLG_DZ = 0;

endpackage

// File: rtl/mc_alu_muldiv.sv
// Iterative sign-magnitude shift-add multiplier and restoring divider, one bit per cycle.
module mc_alu_muldiv #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_p,
  input  logic [WIDTH-1:0] i_q,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic             busy_q;
  logic             div_q;
  logic             neg_q;
  logic             neg_rem_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, mag_q;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [WIDTH-1:0] p_mag, q_mag;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   trial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem;

  assign p_mag = i_p[WIDTH-1] ? -i_p : i_p;
  assign q_mag = i_q[WIDTH-1] ? -i_q : i_q;

  // Remainder stays below the divisor magnitude (<= 2^(WIDTH-1)), so a
  // WIDTH+1 bit trial subtraction carries its sign in the top bit.
  always_comb begin
    hi_n    = hi_q;
    lo_n    = lo_q;
    add_sum = '0;
    trial   = '0;
    if (div_q) begin
      trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, mag_q};
      if (!trial[WIDTH]) begin
        hi_n = trial[WIDTH-1:0];
        lo_n = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        lo_n = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
      hi_n    = add_sum[WIDTH:1];
      lo_n    = {add_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign prod = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
  assign quo  = neg_q ? -lo_n : lo_n;
  assign rem  = neg_rem_q ? -hi_n : hi_n;

  assign o_done = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign o_hi   = div_q ? rem : prod[2*WIDTH-1:WIDTH];
  assign o_lo   = div_q ? quo : prod[WIDTH-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q    <= 1'b0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      mag_q     <= '0;
    end else if (i_start) begin
      busy_q    <= 1'b1;
      div_q     <= i_div;
      neg_q     <= i_p[WIDTH-1] ^ i_q[WIDTH-1];
      neg_rem_q <= i_p[WIDTH-1];
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= p_mag;
      mag_q     <= q_mag;
    end else if (busy_q) begin
      hi_q <= hi_n;
      lo_q <= lo_n;
      if (o_done) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: control FSM, single-cycle datapath, BR/MR/flag registers and bus gating.
module mc_alu
  import mc_alu_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter bit          MULDIV_EN = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_acc_alu_p,
  input  logic [WIDTH-1:0] i_acc_alu_q,
  input  logic [3:0]       ctrl_alu_op,
  input  logic             ctrl_alu_start,
  output logic             o_busy,
  output logic             o_done,
  input  logic             C9,
  input  logic             C10,
  output logic [WIDTH-1:0] o_br,
  output logic [WIDTH-1:0] o_mr,
  output logic [5:0]       o_flags,
  input  logic             i_user_sample,
  output logic [WIDTH-1:0] o_mr_user
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam int unsigned      MSB     = WIDTH - 1;

  state_e state_q, state_d;

  logic [WIDTH-1:0] br_q, mr_q;
  logic [FLG_W-1:0] flags_q;
  logic             div_ovf_q;

  logic             accept, op_mpy, op_div, div_zero, md_start, md_done;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic [WIDTH-1:0] sc_br, sc_mr;
  logic             sc_cf, sc_of, sc_dz, sc_legal;
  logic [FLG_W-1:0] sc_flags, md_flags;
  logic [WIDTH:0]   add_full, sub_full, shl_full, shr_full;

  assign accept   = (state_q == ST_IDLE) && ctrl_alu_start;
  assign op_mpy   = MULDIV_EN && (ctrl_alu_op == OP_MPY);
  assign op_div   = MULDIV_EN && (ctrl_alu_op == OP_DIV);
  assign div_zero = op_div && (i_acc_alu_q == '0);
  assign md_start = accept && (op_mpy || (op_div && !div_zero));

  mc_alu_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (md_start),
    .i_div   (op_div),
    .i_p     (i_acc_alu_p),
    .i_q     (i_acc_alu_q),
    .o_done  (md_done),
    .o_hi    (md_hi),
    .o_lo    (md_lo)
  );

  // Shifts keep one extra bit beside the result so the last bit shifted out
  // falls into it; any amount beyond WIDTH naturally saturates.
  always_comb begin
    add_full = {1'b0, i_acc_alu_p} + {1'b0, i_acc_alu_q};
    sub_full = {1'b0, i_acc_alu_p} - {1'b0, i_acc_alu_q};
    shl_full = {1'b0, i_acc_alu_p} << i_acc_alu_q;
    shr_full = $signed({i_acc_alu_p, 1'b0}) >>> i_acc_alu_q;
    sc_br    = '0;
    sc_mr    = mr_q;
    sc_cf    = 1'b0;
    sc_of    = 1'b0;
    sc_dz    = 1'b0;
    sc_legal = 1'b1;
    case (alu_op_e'(ctrl_alu_op))
      OP_ADD: begin
        sc_br = add_full[WIDTH-1:0];
        sc_cf = add_full[WIDTH];
        sc_of = (i_acc_alu_p[MSB] == i_acc_alu_q[MSB]) && (add_full[MSB] != i_acc_alu_p[MSB]);
      end
      OP_SUB: begin
        sc_br = sub_full[WIDTH-1:0];
        sc_cf = sub_full[WIDTH];
        sc_of = (i_acc_alu_p[MSB] != i_acc_alu_q[MSB]) && (sub_full[MSB] != i_acc_alu_p[MSB]);
      end
      OP_AND: sc_br = i_acc_alu_p & i_acc_alu_q;
      OP_OR:  sc_br = i_acc_alu_p | i_acc_alu_q;
      OP_NOT: sc_br = ~i_acc_alu_p;
      OP_SHR: begin
        sc_br = shr_full[WIDTH:1];
        sc_cf = shr_full[0];
      end
      OP_SHL: begin
        sc_br = shl_full[WIDTH-1:0];
        sc_cf = shl_full[WIDTH];
      end
      OP_DIV: begin
        if (div_zero) begin
          sc_br = '1;
          sc_mr = i_acc_alu_p;
          sc_dz = 1'b1;
        end else begin
          sc_legal = 1'b0;
        end
      end
      default: sc_legal = 1'b0;
    endcase
    sc_flags = '0;
    if (sc_legal) begin
      sc_flags[FLG_ZF] = (sc_br == '0);
      sc_flags[FLG_CF] = sc_cf;
      sc_flags[FLG_OF] = sc_of;
      sc_flags[FLG_NF] = sc_br[MSB];
      sc_flags[FLG_MF] = (sc_mr != '0);
      sc_flags[FLG_DZ] = sc_dz;
    end
  end

  always_comb begin
    md_flags = '0;
    if (state_q == ST_MUL) begin
      md_flags[FLG_ZF] = ({md_hi, md_lo} == '0);
      md_flags[FLG_OF] = (md_hi != {WIDTH{md_lo[MSB]}});
      md_flags[FLG_NF] = md_hi[MSB];
    end else begin
      md_flags[FLG_ZF] = (md_lo == '0);
      md_flags[FLG_OF] = div_ovf_q;
      md_flags[FLG_NF] = md_lo[MSB];
    end
    md_flags[FLG_MF] = (md_hi != '0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!md_start)   state_d = ST_DONE;
          else if (op_mpy) state_d = ST_MUL;
          else             state_d = ST_DIV;
        end
      end
      ST_MUL, ST_DIV: if (md_done) state_d = ST_DONE;
      ST_DONE:        state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      br_q      <= '0;
      mr_q      <= '0;
      flags_q   <= '0;
      div_ovf_q <= 1'b0;
    end else begin
      if (accept && !md_start) begin
        br_q    <= sc_br;
        mr_q    <= sc_mr;
        flags_q <= sc_flags;
      end else if (((state_q == ST_MUL) || (state_q == ST_DIV)) && md_done) begin
        br_q    <= md_lo;
        mr_q    <= md_hi;
        flags_q <= md_flags;
      end else if ((state_q == ST_IDLE) && !accept && C10 && !i_user_sample) begin
        mr_q <= '0;
      end
      if (md_start) begin
        div_ovf_q <= (i_acc_alu_p == MIN_VAL) && (i_acc_alu_q == '1);
      end
    end
  end

  assign o_busy    = (state_q != ST_IDLE);
  assign o_done    = (state_q == ST_DONE);
  assign o_flags   = flags_q;
  assign o_br      = C9 ? br_q : '0;
  assign o_mr      = C10 ? mr_q : '0;
  assign o_mr_user = i_user_sample ? mr_q : '0;

endmodule
